// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART transmit-path bundle for uart_tx_arbiter.
// Requesters and the UART stub drive the master side; the arbiter is the slave.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 uart_tx_start;
    logic [31:0]          uart_tx_data;
    logic                 uart_tx_done;

    modport master (
        output req_valid, req_data, req_last, uart_tx_done,
        input  req_ready, uart_tx_start, uart_tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_tx_done,
        output req_ready, uart_tx_start, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit path between byte requesters.
// A requester keeps the grant until its last byte is sent; each byte is watchdog-guarded.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic               busy,
    output logic [NUM_REQ-1:0] cur_grant,
    output logic               timeout_err
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      win_q;
    logic               lock;
    logic               last_q;
    logic [WW-1:0]      wdog;

    logic               found;
    logic [PW-1:0]      pick;
    logic [PW-1:0]      cand;
    logic [PW-1:0]      nxt_ptr;
    logic [NUM_REQ-1:0] pick_oh;
    logic [7:0]         pick_data;
    logic               done_ok;

    // A set lock makes the locked requester the only candidate.
    always_comb begin
        found = 1'b0;
        pick  = win_q;
        cand  = '0;
        if (lock) begin
            found = bus.req_valid[win_q];
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
                if (!found && bus.req_valid[cand]) begin
                    found = 1'b1;
                    pick  = cand;
                end
            end
        end
    end

    assign pick_oh   = NUM_REQ'(1) << pick;
    assign pick_data = bus.req_data[{pick, 3'b000} +: 8];
    assign nxt_ptr   = PW'((int'(win_q) + 1) % NUM_REQ);
    // wdog is zero only in the start cycle, where done is ignored.
    assign done_ok   = bus.uart_tx_done && (wdog != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            win_q             <= '0;
            lock              <= 1'b0;
            last_q            <= 1'b0;
            wdog              <= '0;
            busy              <= 1'b0;
            cur_grant         <= '0;
            timeout_err       <= 1'b0;
            bus.req_ready     <= '0;
            bus.uart_tx_start <= 1'b0;
            bus.uart_tx_data  <= '0;
        end else begin
            bus.req_ready     <= '0;
            bus.uart_tx_start <= 1'b0;
            timeout_err       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state             <= SEND;
                        win_q             <= pick;
                        last_q            <= bus.req_last[pick];
                        cur_grant         <= pick_oh;
                        bus.uart_tx_data  <= {24'd0, pick_data};
                        bus.req_ready     <= pick_oh;
                        bus.uart_tx_start <= 1'b1;
                        wdog              <= '0;
                        busy              <= 1'b1;
                    end
                end
                SEND: begin
                    wdog <= wdog + 1'b1;
                    if (done_ok) begin
                        state <= GAP;
                        if (last_q) begin
                            lock      <= 1'b0;
                            rr_ptr    <= nxt_ptr;
                            cur_grant <= '0;
                        end else begin
                            lock <= 1'b1;
                        end
                    end else if (wdog == WD_LAST) begin
                        state       <= GAP;
                        timeout_err <= 1'b1;
                        lock        <= 1'b0;
                        rr_ptr      <= nxt_ptr;
                        cur_grant   <= '0;
                    end
                end
                GAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a UART done stub,
// and a monitor logging every start pulse for hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         busy;
    logic         timeout_err;
    logic [N-1:0] cur_grant;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .cur_grant(cur_grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] q_d [N][32];
    logic       q_l [N][32];
    int         head [N];
    int         tail [N];

    logic [7:0]   log_data [$];
    logic [N-1:0] log_grant [$];
    int           log_cyc [$];

    int to_cnt = 0;
    int to_cyc = 0;
    int rdy_bad = 0;
    int lock_bad = 0;
    bit lock_chk = 1'b0;
    int lock_base = 0;
    bit stub_en = 1'b1;
    int stub_k = 6;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        q_d[r][tail[r] % 32] = d;
        q_l[r][tail[r] % 32] = l;
        tail[r]++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_sent(input string tag, input int n);
        int k;
        k = 0;
        while (!((log_data.size() >= n) && !busy) && k < 400) begin
            step();
            k++;
        end
        check({tag, "_wait"}, 32'(k < 400), 32'd1);
    endtask

    task automatic do_reset();
        for (int r = 0; r < N; r++) tail[r] = head[r];
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Monitor and requester driver: sole writer of req_* and head[].
    initial begin
        for (int r = 0; r < N; r++) head[r] = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.uart_tx_start) begin
                log_data.push_back(bus.uart_tx_data[7:0]);
                log_grant.push_back(cur_grant);
                log_cyc.push_back(cyc);
            end
            if (bus.req_ready != (bus.uart_tx_start ? cur_grant : '0))
                rdy_bad++;
            if (timeout_err) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (lock_chk && ((log_data.size() - lock_base) inside {[1:2]})
                && cur_grant != 4'b0010)
                lock_bad++;
            for (int r = 0; r < N; r++)
                if (bus.req_ready[r]) head[r]++;
            for (int r = 0; r < N; r++) begin
                bus.req_valid[r]       = (head[r] != tail[r]);
                bus.req_data[8*r +: 8] = q_d[r][head[r] % 32];
                bus.req_last[r]        = q_l[r][head[r] % 32];
            end
        end
    end

    // UART stub: done pulses in the stub_k-th cycle counted from the start cycle.
    initial begin
        bus.uart_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && stub_en && bus.uart_tx_start) begin
                repeat (stub_k - 1) @(posedge clk);
                #1 bus.uart_tx_done = 1'b1;
                @(posedge clk);
                #1 bus.uart_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int lb;
        int cv;
        int tb0;
        int k;
        for (int r = 0; r < N; r++) tail[r] = 0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(bus.uart_tx_start), 32'd0);
        check("rst_data", bus.uart_tx_data, 32'd0);
        check("rst_grant", 32'(cur_grant), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_to", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        lb = log_data.size();
        push(0, 8'h55, 1'b1);
        step();
        cv = cyc;
        wait_sent("single", lb + 1);
        check("single_lat", 32'(log_cyc[lb] - cv), 32'd1);
        check("single_data", bus.uart_tx_data, 32'h0000_0055);
        check("single_grant", 32'(log_grant[lb]), 32'h1);
        check("single_idle", 32'({busy, cur_grant}), 32'd0);

        lb = log_data.size();
        push(0, 8'h66, 1'b1);
        push(1, 8'h67, 1'b1);
        wait_sent("rrptr", lb + 2);
        check("rrptr_first", 32'(log_grant[lb]), 32'h2);
        check("rrptr_data", 32'(log_data[lb]), 32'h67);
        check("rrptr_second", 32'(log_grant[lb + 1]), 32'h1);

        do_reset();
        lb = log_data.size();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < N; r++)
                push(r, 8'(16 * (r + 1) + b), 1'b1);
        wait_sent("fair", lb + 8);
        for (int i = 0; i < 5; i++)
            check("fair_grant", 32'(log_grant[lb + i]), 32'd1 << (i % 4));
        for (int i = 0; i < 8; i++)
            check("fair_data", 32'(log_data[lb + i]),
                  32'(16 * (i % 4 + 1) + i / 4));
        for (int i = 0; i < 4; i++)
            check("fair_gap", 32'(log_cyc[lb + i + 1] - log_cyc[lb + i]), 32'd8);

        do_reset();
        lb = log_data.size();
        lock_base = lb;
        lock_chk = 1'b1;
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        push(2, 8'hB0, 1'b1);
        wait_sent("lock", lb + 4);
        lock_chk = 1'b0;
        check("lock_data", {log_data[lb], log_data[lb + 1],
                            log_data[lb + 2], log_data[lb + 3]}, 32'hA1A2_A3B0);
        check("lock_grant", 32'({log_grant[lb], log_grant[lb + 1],
                                 log_grant[lb + 2], log_grant[lb + 3]}), 32'h2224);
        check("lock_hold", 32'(lock_bad), 32'd0);

        do_reset();
        lb = log_data.size();
        tb0 = to_cnt;
        push(2, 8'h70, 1'b0);
        push(2, 8'h77, 1'b0);
        push(3, 8'h88, 1'b1);
        k = 0;
        while (log_data.size() < lb + 1 && k < 100) begin
            step();
            k++;
        end
        check("wd_first", 32'(k < 100), 32'd1);
        stub_en = 1'b0;
        k = 0;
        while (to_cnt == tb0 && k < 200) begin
            step();
            k++;
        end
        check("wd_fire", 32'(k < 200), 32'd1);
        stub_en = 1'b1;
        wait_sent("wd", lb + 3);
        check("wd_data", 32'({log_data[lb], log_data[lb + 1], log_data[lb + 2]}),
              32'h70_7788);
        check("wd_grant", 32'({log_grant[lb], log_grant[lb + 1], log_grant[lb + 2]}),
              32'h448);
        check("wd_when", 32'(to_cyc - log_cyc[lb + 1]), 32'd16);
        check("wd_next", 32'(log_cyc[lb + 2] - log_cyc[lb + 1]), 32'd18);
        check("wd_once", 32'(to_cnt - tb0), 32'd1);

        do_reset();
        stub_k = 16;
        tb0 = to_cnt;
        lb = log_data.size();
        push(0, 8'h5A, 1'b1);
        wait_sent("term", lb + 1);
        stub_k = 6;
        check("term_noto", 32'(to_cnt - tb0), 32'd0);
        check("term_grant", 32'(cur_grant), 32'd0);
        lb = log_data.size();
        push(0, 8'h5B, 1'b1);
        push(1, 8'h5C, 1'b1);
        wait_sent("term_rr", lb + 2);
        check("term_rr", 32'(log_grant[lb]), 32'h2);

        do_reset();
        lb = log_data.size();
        push(1, 8'hC1, 1'b0);
        push(1, 8'hC2, 1'b0);
        push(1, 8'hC3, 1'b1);
        k = 0;
        while (log_data.size() < lb + 2 && k < 100) begin
            step();
            k++;
        end
        check("mid_second", 32'(k < 100), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_ctl", 32'({busy, bus.uart_tx_start, timeout_err}), 32'd0);
        check("mid_data", bus.uart_tx_data, 32'd0);
        check("mid_grant", 32'({cur_grant, bus.req_ready}), 32'd0);
        for (int r = 0; r < N; r++) tail[r] = head[r];
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        lb = log_data.size();
        push(0, 8'hD0, 1'b1);
        push(3, 8'hD3, 1'b1);
        wait_sent("mid_after", lb + 2);
        check("mid_first", 32'(log_grant[lb]), 32'h1);
        check("mid_first_data", 32'(log_data[lb]), 32'hD0);
        check("mid_second_grant", 32'(log_grant[lb + 1]), 32'h8);

        check("ready_start", 32'(rdy_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmit path of the UART controller between up to `NUM_REQ` byte requesters. It uses round-robin arbitration with message locking: a requester keeps the grant until its `last` byte has been sent. The block sequences each byte as one `uart_tx_start` pulse, then waits for `uart_tx_done`, guarded by a watchdog. It sits between the firmware/peripheral message sources and the UART controller's `tx_start`/`tx_data`/`tx_done` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 1..8.
- `TIMEOUT_CYCLES`, 8192: maximum cycles to wait for `uart_tx_done` per byte. Must exceed 10×baud divisor.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte available.
- `req_data` in 8*NUM_REQ: byte for requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: byte is the final byte of its message.
- `req_ready` out NUM_REQ: one-hot, one-cycle pulse; the byte is consumed at this edge.
- `uart_tx_start` out 1: one-cycle start pulse to the UART.
- `uart_tx_data` out 32: `{24'd0, byte}`, held stable until the next capture.
- `uart_tx_done` in 1: UART end-of-frame pulse.
- `busy` out 1: high in any state other than IDLE.
- `cur_grant` out NUM_REQ: one-hot index of the requester being served or locked, 0 when none.
- `timeout_err` out 1: one-cycle pulse when the watchdog expires.

## Operation
- States: IDLE, SEND, GAP.
- Requester rule: hold `req_valid`, `req_data` and `req_last` stable until `req_ready` is seen.
- **IDLE, lock clear:** winner is the first asserted `req_valid` searching upward from `rr_ptr`, with wrap-around.
- **IDLE, lock set:** only the locked index is eligible; other requesters are ignored.
- **IDLE, winner found:** capture data into `uart_tx_data`, capture `last` into `last_q`, record the winner in `cur_grant`, go to SEND.
- **SEND, first cycle:**
  - `req_ready[winner]` = 1 and `uart_tx_start` = 1, both for exactly that cycle.
  - Watchdog counter cleared on SEND entry, then increments each SEND cycle.
- **SEND, `uart_tx_done` = 1:**
  - If `last_q` = 1: clear lock, set `rr_ptr` = (winner + 1) mod NUM_REQ, clear `cur_grant`.
  - Otherwise: set lock to the winner.
  - Go to GAP.
- **SEND, watchdog reaches TIMEOUT_CYCLES-1 with no done:** pulse `timeout_err` the next cycle, clear lock, advance `rr_ptr` as for a completed message, go to GAP.
- **GAP:** one cycle, always returns to IDLE. This guarantees the UART has left its active state before the next start.
- Lock held with no further valid: wait indefinitely. No watchdog runs in IDLE.

## Timing
- Reset values:
  - All outputs 0, including `uart_tx_data` = 0.
  - State IDLE, `rr_ptr` = 0, lock clear, watchdog 0.
- Arbitration latency: valid sampled at edge E → `req_ready` and `uart_tx_start` high in the cycle after E.
- Back-to-back: `uart_tx_done` in cycle d → GAP in d+1 → IDLE samples in d+2 → next `uart_tx_start` in d+3.
- `uart_tx_done` and watchdog terminal count in the same cycle: done wins, no `timeout_err`.
- `uart_tx_done` in IDLE or GAP, or in the start cycle of SEND: ignored.
- Counter width is `clog2(TIMEOUT_CYCLES)`.
- `rr_ptr` width is `max(1, clog2(NUM_REQ))`, with modulo wrap.
- Reset mid-operation: asynchronous clear to the reset values. A partial message is abandoned and the requester must resend.
- NUM_REQ = 1: arbitration degenerates to a fixed grant. Locking is unchanged.

## Test plan
- **Single byte:** UART stub at baud_div 4; `req_valid[0]` = 1, data 0x55, last = 1.
  - `req_ready[0]` and `uart_tx_start` pulse one cycle after valid is sampled.
  - `uart_tx_data` = 0x00000055.
  - `busy` drops after GAP; `rr_ptr` = 1.
- **Fair rotation:** all 4 requesters continuously valid, each byte with last = 1. Grant order is 0, 1, 2, 3, 0, and `uart_tx_start` spacing is exactly done+3.
- **Message lock:** requester 1 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) while requester 2 is valid throughout. The UART sees A1, A2, A3 contiguously, then requester 2's byte; `cur_grant` = 0010 throughout.
- **Watchdog expiry:** `TIMEOUT_CYCLES` = 16, `uart_tx_done` tied 0.
  - `timeout_err` pulses once, in the cycle after the 16th SEND cycle.
  - Lock cleared; the next requester is served after GAP.
- **Done on terminal count:** `TIMEOUT_CYCLES` = 16, `uart_tx_done` asserted in the 16th SEND cycle. No `timeout_err`; normal completion.
- **Reset mid-SEND:** `rst_n` asserted during the second byte of a locked message.
  - All outputs 0 immediately.
  - After release, with requesters 0 and 3 valid, requester 0 wins first.
